// File: rtl/zeroheti_dmem_arb.sv
// Round-robin arbiter between the core data port and the system bus for the zeroHETI DMEM SRAM.
// Range-checks addresses against the DMEM window; out-of-window accesses get an error response.
module zeroheti_dmem_arb #(
    parameter logic [31:0] BaseAddr  = 32'h0002_0000,
    parameter int unsigned SizeBytes = 16384,
    localparam int unsigned WordAw   = $clog2(SizeBytes / 4)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             m_req_i,
    output logic [1:0]             m_gnt_o,
    input  logic [1:0][31:0]       m_addr_i,
    input  logic [1:0]             m_we_i,
    input  logic [1:0][3:0]        m_be_i,
    input  logic [1:0][31:0]       m_wdata_i,
    output logic [1:0]             m_rvalid_o,
    output logic [1:0][31:0]       m_rdata_o,
    output logic [1:0]             m_err_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [WordAw-1:0]      mem_addr_o,
    output logic [3:0]             mem_be_o,
    output logic [31:0]            mem_wdata_o,
    input  logic [31:0]            mem_rdata_i
);

    logic        prio_q, prio_d;
    logic        rsp_valid_q, rsp_id_q, rsp_err_q, rsp_we_q;
    logic        gnt_any, gnt_id;
    logic [31:0] sel_addr, offset;
    logic        in_range;

    // Grant is suppressed during reset so nothing reaches the SRAM.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (!rst_i) begin
            unique case (m_req_i)
                2'b01: begin gnt_any = 1'b1; gnt_id = 1'b0;   end
                2'b10: begin gnt_any = 1'b1; gnt_id = 1'b1;   end
                2'b11: begin gnt_any = 1'b1; gnt_id = prio_q; end
                default: ;
            endcase
        end
    end

    always_comb begin
        sel_addr = m_addr_i[gnt_id];
        offset   = sel_addr - BaseAddr;
        in_range = (sel_addr >= BaseAddr) && (offset < 32'(SizeBytes));
        prio_d   = gnt_any ? ~gnt_id : prio_q;
    end

    always_comb begin
        m_gnt_o     = gnt_any ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
        mem_req_o   = gnt_any & in_range;
        mem_we_o    = gnt_any ? m_we_i[gnt_id] : 1'b0;
        mem_addr_o  = gnt_any ? offset[WordAw+1:2] : '0;
        mem_be_o    = gnt_any ? m_be_i[gnt_id] : 4'h0;
        mem_wdata_o = gnt_any ? m_wdata_i[gnt_id] : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            rsp_valid_q <= gnt_any;
            if (gnt_any) begin
                rsp_id_q  <= gnt_id;
                rsp_err_q <= ~in_range;
                rsp_we_q  <= m_we_i[gnt_id];
            end
        end
    end

    // A response still held while reset is asserted is dropped, not delivered.
    always_comb begin
        m_rvalid_o = 2'b00;
        m_err_o    = 2'b00;
        m_rdata_o  = '0;
        if (rsp_valid_q && !rst_i) begin
            m_rvalid_o[rsp_id_q] = 1'b1;
            m_err_o[rsp_id_q]    = rsp_err_q;
            if (!rsp_err_q && !rsp_we_q) begin
                m_rdata_o[rsp_id_q] = mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_zeroheti_dmem_arb.sv
// Bench for zeroheti_dmem_arb: directed vector table, hand sequences and random traffic
// against a transaction-level model with its own reference memory.
module tb_zeroheti_dmem_arb;

    localparam logic [31:0] Base  = 32'h0002_0000;
    localparam int unsigned Size  = 16384;
    localparam int          Words = 4096;

    logic              clk;
    logic              rst_i;
    logic [1:0]        m_req_i;
    logic [1:0]        m_gnt_o;
    logic [1:0][31:0]  m_addr_i;
    logic [1:0]        m_we_i;
    logic [1:0][3:0]   m_be_i;
    logic [1:0][31:0]  m_wdata_i;
    logic [1:0]        m_rvalid_o;
    logic [1:0][31:0]  m_rdata_o;
    logic [1:0]        m_err_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [11:0]       mem_addr_o;
    logic [3:0]        mem_be_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    zeroheti_dmem_arb #(
        .BaseAddr  (Base),
        .SizeBytes (Size)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .m_req_i     (m_req_i),
        .m_gnt_o     (m_gnt_o),
        .m_addr_i    (m_addr_i),
        .m_we_i      (m_we_i),
        .m_be_i      (m_be_i),
        .m_wdata_i   (m_wdata_i),
        .m_rvalid_o  (m_rvalid_o),
        .m_rdata_o   (m_rdata_o),
        .m_err_o     (m_err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro: single port, one-cycle read latency, byte-enabled writes.
    bit   [31:0] sram [Words];
    logic [31:0] sram_w;
    initial mem_rdata_i = 32'h0;
    always @(posedge clk) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                sram_w = sram[mem_addr_o];
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
                sram[mem_addr_o] <= sram_w;
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference model: transaction-level state.
    bit          m_prio = 1'b0;
    bit          p_valid = 1'b0;
    bit          p_id = 1'b0;
    bit          p_err = 1'b0;
    logic [31:0] p_data = 32'h0;
    logic [31:0] refmem [int];

    function automatic logic [31:0] ref_rd(int k);
        return refmem.exists(k) ? refmem[k] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input logic [1:0] req, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [1:0] we, input logic [3:0] be,
                        input logic [31:0] wd0, input logic [31:0] wd1, input bit tbl,
                        input logic [1:0] tgnt, input bit tmreq, input logic [31:0] tmaddr);
        bit              g_any, g, inr;
        logic [31:0]     ga, gwd;
        longint unsigned ua;
        int              k;
        logic [1:0]      ev, ee;
        logic [31:0]     ed0, ed1, w;

        rst_i = rst; m_req_i = req; m_addr_i[0] = a0; m_addr_i[1] = a1; m_we_i = we;
        m_be_i[0] = be; m_be_i[1] = be; m_wdata_i[0] = wd0; m_wdata_i[1] = wd1;
        #4;
        g_any = !rst && (req != 2'b00);
        g     = (req == 2'b11) ? m_prio : req[1];
        ga    = g ? a1 : a0;
        gwd   = g ? wd1 : wd0;
        ua    = longint'(ga);
        inr   = (ua >= longint'(Base)) && (ua < longint'(Base) + longint'(Size));
        k     = int'((ua - longint'(Base)) >> 2);

        chk("gnt", {62'h0, m_gnt_o}, g_any ? (64'h1 << g) : 64'h0);
        chk("mem_req", {63'h0, mem_req_o}, {63'h0, g_any && inr});
        if (g_any && inr) begin
            chk("mem_addr", {52'h0, mem_addr_o}, 64'(k));
            chk("mem_we", {63'h0, mem_we_o}, {63'h0, we[g]});
            chk("mem_be", {60'h0, mem_be_o}, {60'h0, be});
            chk("mem_wdata", {32'h0, mem_wdata_o}, {32'h0, gwd});
        end
        if (!g_any)
            chk("mem_idle", {15'h0, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}, 64'h0);

        ev = 2'b00; ee = 2'b00; ed0 = 32'h0; ed1 = 32'h0;
        if (!rst && p_valid) begin
            ev[p_id] = 1'b1;
            ee[p_id] = p_err;
            if (p_id) ed1 = p_data; else ed0 = p_data;
        end
        chk("rvalid", {62'h0, m_rvalid_o}, {62'h0, ev});
        chk("err", {62'h0, m_err_o}, {62'h0, ee});
        chk("rdata0", {32'h0, m_rdata_o[0]}, {32'h0, ed0});
        chk("rdata1", {32'h0, m_rdata_o[1]}, {32'h0, ed1});

        if (tbl) begin
            chk("tbl_gnt", {62'h0, m_gnt_o}, {62'h0, tgnt});
            chk("tbl_mreq", {63'h0, mem_req_o}, {63'h0, tmreq});
            if (tmreq) chk("tbl_maddr", {52'h0, mem_addr_o}, {32'h0, tmaddr});
        end

        @(posedge clk);
        if (rst) begin
            m_prio  = 1'b0;
            p_valid = 1'b0;
        end else if (g_any) begin
            m_prio  = !g;
            p_valid = 1'b1;
            p_id    = g;
            p_err   = !inr;
            p_data  = (!inr || we[g]) ? 32'h0 : ref_rd(k);
            if (inr && we[g]) begin
                w = ref_rd(k);
                for (int b = 0; b < 4; b++)
                    if (be[b]) w[8*b +: 8] = gwd[8*b +: 8];
                refmem[k] = w;
            end
        end else begin
            p_valid = 1'b0;
        end
        #1;
    endtask

    typedef struct packed {
        logic        rst;
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  we;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [1:0]  gnt;
        logic        mreq;
        logic [31:0] maddr;
    } vec_t;

    function automatic logic [31:0] rnd_addr();
        int unsigned sel;
        sel = $urandom_range(0, 9);
        if (sel < 8) return Base + 32'($urandom_range(0, 63));
        if (sel == 8) return Base - 32'($urandom_range(1, 64));
        return Base + Size + 32'($urandom_range(0, 64));
    endfunction

    vec_t vq[$];

    initial begin
        rst_i = 1'b1; m_req_i = 2'b00; m_addr_i = '0; m_we_i = 2'b00;
        m_be_i = '0; m_wdata_i = '0;

        vq.push_back('{1'b1, 2'b11, Base, Base, 2'b00, 4'hF, 32'h0, 2'b00, 1'b0, 32'd0});
        // Write 0xDEADBEEF then read it back as the core.
        vq.push_back('{1'b0, 2'b01, 32'h0002_0010, Base, 2'b01, 4'hF, 32'hDEADBEEF,
                       2'b01, 1'b1, 32'd4});
        vq.push_back('{1'b0, 2'b01, 32'h0002_0010, Base, 2'b00, 4'hF, 32'h0,
                       2'b01, 1'b1, 32'd4});
        vq.push_back('{1'b0, 2'b00, Base, Base, 2'b00, 4'h0, 32'h0, 2'b00, 1'b0, 32'd0});
        // Contention from reset: core, sys, core, sys, core.
        vq.push_back('{1'b1, 2'b00, Base, Base, 2'b00, 4'h0, 32'h0, 2'b00, 1'b0, 32'd0});
        for (int i = 0; i < 5; i++)
            vq.push_back('{1'b0, 2'b11, 32'h0002_0020, 32'h0002_0024, 2'b00, 4'hF, 32'h0,
                           (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, (i % 2 == 0) ? 32'd8 : 32'd9});
        vq.push_back('{1'b0, 2'b00, Base, Base, 2'b00, 4'h0, 32'h0, 2'b00, 1'b0, 32'd0});
        // Window edges seen from the system bus.
        vq.push_back('{1'b0, 2'b10, Base, 32'h0001_FFFC, 2'b00, 4'hF, 32'h0, 2'b10, 1'b0, 32'd0});
        vq.push_back('{1'b0, 2'b10, Base, 32'h0002_4000, 2'b00, 4'hF, 32'h0, 2'b10, 1'b0, 32'd0});
        vq.push_back('{1'b0, 2'b10, Base, 32'h0002_3FFC, 2'b00, 4'hF, 32'h0,
                       2'b10, 1'b1, 32'd4095});
        vq.push_back('{1'b0, 2'b00, Base, Base, 2'b00, 4'h0, 32'h0, 2'b00, 1'b0, 32'd0});
        // Byte-lane write then read: expect 0x00003300.
        vq.push_back('{1'b0, 2'b01, Base, Base, 2'b01, 4'b0010, 32'h1122_3344,
                       2'b01, 1'b1, 32'd0});
        vq.push_back('{1'b0, 2'b01, Base, Base, 2'b00, 4'hF, 32'h0, 2'b01, 1'b1, 32'd0});
        vq.push_back('{1'b0, 2'b00, Base, Base, 2'b00, 4'h0, 32'h0, 2'b00, 1'b0, 32'd0});
        // Reset right after a grant drops its response; core wins afterwards.
        vq.push_back('{1'b0, 2'b01, 32'h0002_0010, Base, 2'b00, 4'hF, 32'h0,
                       2'b01, 1'b1, 32'd4});
        vq.push_back('{1'b1, 2'b01, 32'h0002_0010, Base, 2'b00, 4'hF, 32'h0,
                       2'b00, 1'b0, 32'd0});
        vq.push_back('{1'b0, 2'b11, 32'h0002_0010, 32'h0002_0024, 2'b00, 4'hF, 32'h0,
                       2'b01, 1'b1, 32'd4});
        vq.push_back('{1'b0, 2'b00, Base, Base, 2'b00, 4'h0, 32'h0, 2'b00, 1'b0, 32'd0});

        foreach (vq[i])
            step(vq[i].rst, vq[i].req, vq[i].a0, vq[i].a1, vq[i].we, vq[i].be, vq[i].wd,
                 vq[i].wd, 1'b1, vq[i].gnt, vq[i].mreq, vq[i].maddr);

        // Explicit check of the byte-lane merge result held in the SRAM.
        chk("byte_merge", {32'h0, 32'(sram[0])}, 64'h0000_3300);

        // Sys streams writes then 8 back-to-back reads over them.
        for (int i = 0; i < 8; i++)
            step(1'b0, 2'b10, Base, Base + 32'(64 + 4 * i), 2'b10, 4'hF, 32'h0,
                 32'hA500_0000 + 32'(i), 1'b1, 2'b10, 1'b1, 32'(16 + i));
        for (int i = 0; i < 8; i++)
            step(1'b0, 2'b10, Base, Base + 32'(64 + 4 * i), 2'b00, 4'hF, 32'h0, 32'h0,
                 1'b1, 2'b10, 1'b1, 32'(16 + i));
        step(1'b0, 2'b00, Base, Base, 2'b00, 4'h0, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 32'd0);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, 2'($urandom), rnd_addr(), rnd_addr(),
                 2'($urandom), 4'($urandom), $urandom, $urandom, 1'b0, 2'b00, 1'b0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
